// File: rtl/e203_exu_wbck_arbn.sv
// N-channel write-back arbiter: fixed priority with per-channel starvation override,
// one output register stage. Define E203_WBCK_RR_EN for round-robin base arbitration.
module e203_exu_wbck_arbn #(
  parameter int unsigned CH_N       = 3,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FLEN       = 32,
  parameter int unsigned RFIDX_W    = 5,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_N-1:0]         wbck_i_valid,
  output logic [CH_N-1:0]         wbck_i_ready,
  input  logic [CH_N*FLEN-1:0]    wbck_i_wdat,
  input  logic [CH_N*5-1:0]       wbck_i_flags,
  input  logic [CH_N*RFIDX_W-1:0] wbck_i_rdidx,
  input  logic [CH_N-1:0]         wbck_i_rdfpu,
  output logic                    rf_wbck_o_ena,
  output logic [XLEN-1:0]         rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]      rf_wbck_o_rdidx,
  output logic                    frf_wbck_o_ena,
  output logic [FLEN-1:0]         frf_wbck_o_wdat,
  output logic [4:0]              frf_wbck_o_flags,
  output logic [RFIDX_W-1:0]      frf_wbck_o_rdidx
);

  localparam int unsigned CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int unsigned IDX_W = $clog2(CH_N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0]   cnt_q [CH_N];
  logic [CNT_W-1:0]   cnt_d [CH_N];
  logic [CH_N-1:0]    grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [FLEN-1:0]    sel_wdat;
  logic [4:0]         sel_flags;
  logic [RFIDX_W-1:0] sel_rdidx;
  logic               sel_rdfpu;

  logic                rf_ena_q, frf_ena_q;
  logic [XLEN-1:0]     rf_wdat_q;
  logic [RFIDX_W-1:0]  rf_rdidx_q, frf_rdidx_q;
  logic [FLEN-1:0]     frf_wdat_q;
  logic [4:0]          frf_flags_q;

`ifdef E203_WBCK_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  always_comb begin : arb
    int unsigned j;
    j       = 0;
    grant   = '0;
    win_idx = '0;
    win_vld = 1'b0;
    // Starvation override outranks the base arbitration.
    if (STARVE_LIM > 0) begin
      for (int unsigned i = 0; i < CH_N; i++) begin
        if (!win_vld && wbck_i_valid[i] && (cnt_q[i] == CNT_MAX)) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end
`ifdef E203_WBCK_RR_EN
    for (int unsigned off = 0; off < CH_N; off++) begin
      j = 32'(ptr_q) + off;
      if (j >= CH_N) j = j - CH_N;
      if (!win_vld && wbck_i_valid[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
`else
    for (int unsigned i = 0; i < CH_N; i++) begin
      if (!win_vld && wbck_i_valid[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
`endif
    if (win_vld) grant[win_idx] = 1'b1;
  end

  always_comb begin : payload_mux
    sel_wdat  = '0;
    sel_flags = '0;
    sel_rdidx = '0;
    sel_rdfpu = 1'b0;
    for (int unsigned i = 0; i < CH_N; i++) begin
      if (grant[i]) begin
        sel_wdat  = wbck_i_wdat[i*FLEN +: FLEN];
        sel_flags = wbck_i_flags[i*5 +: 5];
        sel_rdidx = wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
        sel_rdfpu = wbck_i_rdfpu[i];
      end
    end
  end

  always_comb begin : cnt_next
    for (int unsigned i = 0; i < CH_N; i++) begin
      cnt_d[i] = '0;
      if (wbck_i_valid[i] && !grant[i]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_N; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ena_q    <= 1'b0;
      rf_wdat_q   <= '0;
      rf_rdidx_q  <= '0;
      frf_ena_q   <= 1'b0;
      frf_wdat_q  <= '0;
      frf_flags_q <= '0;
      frf_rdidx_q <= '0;
    end else begin
      rf_ena_q  <= win_vld && !sel_rdfpu;
      frf_ena_q <= win_vld && sel_rdfpu;
      if (win_vld && !sel_rdfpu) begin
        rf_wdat_q  <= sel_wdat[XLEN-1:0];
        rf_rdidx_q <= sel_rdidx;
      end
      if (win_vld && sel_rdfpu) begin
        frf_wdat_q  <= sel_wdat;
        frf_flags_q <= sel_flags;
        frf_rdidx_q <= sel_rdidx;
      end
    end
  end

`ifdef E203_WBCK_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) ptr_d = (win_idx == IDX_W'(CH_N - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign wbck_i_ready     = grant;
  assign rf_wbck_o_ena    = rf_ena_q;
  assign rf_wbck_o_wdat   = rf_wdat_q;
  assign rf_wbck_o_rdidx  = rf_rdidx_q;
  assign frf_wbck_o_ena   = frf_ena_q;
  assign frf_wbck_o_wdat  = frf_wdat_q;
  assign frf_wbck_o_flags = frf_flags_q;
  assign frf_wbck_o_rdidx = frf_rdidx_q;

endmodule

// File: doc/e203_exu_wbck_arbn.md
Name: e203_exu_wbck_arbn

Overview:
- Parametrised N-channel write-back arbiter. Successor to the two-source (ALU/long-pipe) write-back arbitration.
- Selects one of CH_N requesters per cycle and routes the winner to the integer or FP regfile write port through one output register stage.
- Fixed priority with a starvation-override counter per channel; optional round-robin base arbitration.
- Sits between the EU/long-pipe write-back sources and the regfiles in the EXU.

Parameters:
- CH_N, 3, number of write-back requesters (2..8); channel 0 has the highest fixed priority
- XLEN, 32, integer regfile data width
- FLEN, 32, FP/long-pipe data width; constraint FLEN >= XLEN
- RFIDX_W, 5, register index width
- STARVE_LIM, 4, wait cycles before a waiting channel is force-granted; 0 disables the override

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wbck_i_valid  input  CH_N  per-channel write-back request
- wbck_i_ready  output  CH_N  per-channel grant/accept
- wbck_i_wdat  input  CH_N*FLEN  packed data; channel i at [i*FLEN +: FLEN]
- wbck_i_flags  input  CH_N*5  packed FP exception flags
- wbck_i_rdidx  input  CH_N*RFIDX_W  packed destination index
- wbck_i_rdfpu  input  CH_N  1 = destination is the FP regfile
- rf_wbck_o_ena  output  1  integer regfile write enable
- rf_wbck_o_wdat  output  XLEN  integer write data
- rf_wbck_o_rdidx  output  RFIDX_W  integer write index
- frf_wbck_o_ena  output  1  FP regfile write enable
- frf_wbck_o_wdat  output  FLEN  FP write data
- frf_wbck_o_flags  output  5  FP flags accompanying the FP write
- frf_wbck_o_rdidx  output  RFIDX_W  FP write index

Behaviour:
- Reset: rf_wbck_o_ena and frf_wbck_o_ena are 0. All data, index and flag registers are 0. Starvation counters are 0. RR pointer is 0. Reset is asynchronous: asserting rst_n low mid-write clears the outputs immediately.
- Grant selection is combinational and one-hot; at most one channel is granted per cycle.
  - Step 1: if any channel has valid=1 and cnt==STARVE_LIM (with STARVE_LIM>0), grant the lowest-index such channel.
  - Step 2: otherwise, grant the lowest-index valid channel.
  - No channel valid: no grant.
- wbck_i_ready[i] = grant[i]. Ready depends on valid, so it is never asserted to an idle channel.
- A transfer occurs when valid[i] & ready[i]. Sources must hold valid and payload until the transfer.
- The regfiles are always ready, so there is no output backpressure.
- Starvation counter, per channel, width clog2(STARVE_LIM+1):
  - valid & ~grant: increment, saturating at STARVE_LIM.
  - grant or ~valid: clear to 0.
- Output stage, one-cycle latency. On a transfer from channel k, at the next clock edge:
  - rdfpu=0: rf_wbck_o_ena=1, rf_wbck_o_wdat=wdat_k[XLEN-1:0], rf_wbck_o_rdidx=rdidx_k; frf_wbck_o_ena=0.
  - rdfpu=1: frf_wbck_o_ena=1, frf_wbck_o_wdat=wdat_k, frf_wbck_o_flags=flags_k, frf_wbck_o_rdidx=rdidx_k; rf_wbck_o_ena=0.
- Both enables are never 1 in the same cycle.
- With no transfer, both enables are 0 next cycle and the data/index/flag registers hold their values.
- rdidx=0 with rdfpu=0 is passed through unchanged; the regfile discards writes to x0.
- Flags are ignored on integer writes.

Optional Feature:
- Macro: E203_WBCK_RR_EN
- Defined:
  - Step 2 becomes round-robin. The search starts at pointer p and wraps modulo CH_N.
  - After any transfer from channel k, p = (k+1) mod CH_N; with no transfer, p holds.
  - Step 1 (starvation override) still takes precedence.
- Undefined: fixed priority as above; no pointer register is built.

Test Plan:
- Only ch1 valid, wdat=0x12345678, rdidx=5, rdfpu=0 -> wbck_i_ready=3'b010 that cycle; next cycle rf_wbck_o_ena=1, wdat=0x12345678, rdidx=5; following cycle ena=0 and data held.
- ch0 and ch2 valid continuously, STARVE_LIM=4 -> ch0 granted cycles 0-3; ch2 granted cycle 4; ch0 granted cycle 5; ch2 counter returns to 0 after its grant.
- ch0 rdfpu=1, wdat=0x3F800000, flags=5'b00001, rdidx=3 -> next cycle frf_wbck_o_ena=1 with those values, rf_wbck_o_ena=0.
- Transfer in cycle N, rst_n pulled low mid-cycle N+1 -> both enables drop to 0 asynchronously; counters and pointer are 0 after release.
- E203_WBCK_RR_EN defined, all three channels valid continuously -> grants 0,1,2,0,1,2; no starvation override fires.
- STARVE_LIM=0, ch0 and ch2 valid for 20 cycles -> ch2 is never granted; first ch2 grant occurs the cycle after ch0 valid drops.
